// File: rtl/parking_occupancy.sv
// Two-sensor lot gate monitor: decodes entry/exit order of outer (a) and inner (b)
// sensors and keeps a saturating occupancy count with full/empty status.
module parking_occupancy #(
    parameter int CAPACITY    = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [2:0] count,
    output logic       full,
    output logic       empty,
    output logic       enter_p,
    output logic       exit_p,
    output logic       err
);

    localparam logic [2:0] CAP = 3'(CAPACITY);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EN1  = 3'd1;
    localparam logic [2:0] ST_EN2  = 3'd2;
    localparam logic [2:0] ST_EN3  = 3'd3;
    localparam logic [2:0] ST_EX1  = 3'd4;
    localparam logic [2:0] ST_EX2  = 3'd5;
    localparam logic [2:0] ST_EX3  = 3'd6;
    localparam logic [2:0] ST_ERR  = 3'd7;

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             sab;

    logic [2:0] state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       enter_q, enter_d;
    logic       exit_q,  exit_d;
    logic       err_q;

    // Sensor synchronisers; the oldest stage feeds the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b};
        end
    end

    assign sab = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sab == 2'b10)      state_d = ST_EN1;
                else if (sab == 2'b01) state_d = ST_EX1;
                else if (sab == 2'b11) state_d = ST_ERR;
            end
            ST_EN1: begin
                if (sab == 2'b11)      state_d = ST_EN2;
                else if (sab == 2'b00) state_d = ST_IDLE;
                else if (sab == 2'b01) state_d = ST_ERR;
            end
            ST_EN2: begin
                if (sab == 2'b01)      state_d = ST_EN3;
                else if (sab == 2'b10) state_d = ST_EN1;
                else if (sab == 2'b00) state_d = ST_ERR;
            end
            ST_EN3: begin
                if (sab == 2'b00)      state_d = ST_IDLE;
                else if (sab == 2'b11) state_d = ST_EN2;
                else if (sab == 2'b10) state_d = ST_ERR;
            end
            ST_EX1: begin
                if (sab == 2'b11)      state_d = ST_EX2;
                else if (sab == 2'b00) state_d = ST_IDLE;
                else if (sab == 2'b10) state_d = ST_ERR;
            end
            ST_EX2: begin
                if (sab == 2'b10)      state_d = ST_EX3;
                else if (sab == 2'b01) state_d = ST_EX1;
                else if (sab == 2'b00) state_d = ST_ERR;
            end
            ST_EX3: begin
                if (sab == 2'b00)      state_d = ST_IDLE;
                else if (sab == 2'b11) state_d = ST_EX2;
                else if (sab == 2'b01) state_d = ST_ERR;
            end
            default: begin
                if (sab == 2'b00)      state_d = ST_IDLE;
            end
        endcase
    end

    // Pulses fire on every completed pass; the count alone saturates.
    always_comb begin
        enter_d = (state_q == ST_EN3) && (sab == 2'b00);
        exit_d  = (state_q == ST_EX3) && (sab == 2'b00);
        count_d = count_q;
        if (enter_d && (count_q != CAP))
            count_d = count_q + 3'd1;
        else if (exit_d && (count_q != 3'd0))
            count_d = count_q - 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= 3'd0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            err_q   <= (state_d == ST_ERR);
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CAP);
    assign empty   = (count_q == 3'd0);
    assign enter_p = enter_q;
    assign exit_p  = exit_q;
    assign err     = err_q;

endmodule
